// File: rtl/mnist_pkg.sv
// Shared constants, sequencer state type and signed ReLU for the MNIST FC1->FC2 path.
package mnist_pkg;
   localparam int DATA_W      = 32;
   localparam int FC1_NEURONS = 32;
   localparam int FC1_IDX_W   = $clog2(FC1_NEURONS);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DRAIN
   } seq_state_t;

   // Negative results clamp to zero; the sign bit alone decides.
   function automatic logic [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
      return x[DATA_W-1] ? '0 : x;
   endfunction
endpackage

// File: rtl/fc1_relu_sequencer_if.sv
// FC1 result stream into the sequencer and ReLU result stream out toward FC2.
interface fc1_relu_sequencer_if #(
   parameter int DATA_W = mnist_pkg::DATA_W,
   parameter int IDX_W  = mnist_pkg::FC1_IDX_W
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [IDX_W-1:0]  out_idx;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_idx
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_idx
   );
endinterface

// File: rtl/fc1_result_buf.sv
// Frame buffer for FC1 results: one synchronous write port, one combinational read port.
// Contents are deliberately left unreset; every entry is rewritten before it is read in a frame.
module fc1_result_buf #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int IDX_W  = 5
) (
   input  logic              clk,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [IDX_W-1:0]  rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/fc1_relu_sequencer.sv
// Collects one frame of FC1 results, then replays them through signed ReLU to FC2 in index order.
// First out_valid one cycle after the last input accept; out_ready low holds out_idx/out_data.
module fc1_relu_sequencer
   import mnist_pkg::*;
#(
   parameter int DATA_W = mnist_pkg::DATA_W,
   parameter int DEPTH  = mnist_pkg::FC1_NEURONS,
   parameter int IDX_W  = mnist_pkg::FC1_IDX_W
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start_i,
   fc1_relu_sequencer_if.slave  bus,
   output logic                 busy_o,
   output logic                 done_o
);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   seq_state_t        state_q;
   logic [IDX_W-1:0]  wr_ptr_q;
   logic [IDX_W-1:0]  wr_ptr_d;
   logic [IDX_W-1:0]  rd_ptr_q;
   logic [IDX_W-1:0]  rd_ptr_d;
   logic              in_ready_q;
   logic              out_valid_q;
   logic              busy_q;
   logic              done_q;
   logic              wr_fire;
   logic              rd_fire;
   logic [DATA_W-1:0] rd_data;

   // in_ready_q/out_valid_q are high only in FILL/DRAIN, so stray handshakes elsewhere are inert.
   assign wr_fire  = bus.in_valid & in_ready_q;
   assign rd_fire  = out_valid_q & bus.out_ready;
   assign wr_ptr_d = wr_fire ? wr_ptr_q + IDX_W'(1) : wr_ptr_q;
   assign rd_ptr_d = rd_fire ? rd_ptr_q + IDX_W'(1) : rd_ptr_q;

   fc1_result_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_buf (
      .clk       (clk),
      .wr_en_i   (wr_fire),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (bus.in_data),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (rd_data)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_q    <= FILL;
                  wr_ptr_q   <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            FILL: begin
               // The final accept wraps wr_ptr back to zero on its own.
               wr_ptr_q <= wr_ptr_d;
               if (wr_fire && (wr_ptr_q == LAST_IDX)) begin
                  state_q     <= DRAIN;
                  rd_ptr_q    <= '0;
                  in_ready_q  <= 1'b0;
                  out_valid_q <= 1'b1;
               end
            end
            DRAIN: begin
               rd_ptr_q <= rd_ptr_d;
               if (rd_fire && (rd_ptr_q == LAST_IDX)) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_idx   = out_valid_q ? rd_ptr_q : '0;
   assign bus.out_data  = out_valid_q ? relu(rd_data) : '0;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
endmodule

// File: tb/tb_fc1_relu_sequencer.sv
// Frame-level randomized bench: inputs recorded in an array, outputs compared against plain signed ReLU.
module tb_fc1_relu_sequencer;
   localparam int DEPTH = 32;
   localparam int LIMIT = 1000;

   logic clk = 1'b0;
   logic resetn;
   logic start;
   logic busy;
   logic done;

   always #5 clk = ~clk;

   fc1_relu_sequencer_if #(.DATA_W(32), .IDX_W(5)) bus ();

   fc1_relu_sequencer dut (
      .clk     (clk),
      .resetn  (resetn),
      .start_i (start),
      .bus     (bus.slave),
      .busy_o  (busy),
      .done_o  (done)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] vals    [DEPTH];
   logic [31:0] got_dat [DEPTH];
   logic [4:0]  got_idx [DEPTH];
   logic [4:0]  st_idx  [8];
   logic [31:0] st_dat  [8];
   logic        st_ov   [8];
   int          n_done, done_cyc, ov_early, st_n, in_rdy_drain;
   bit          timeout, ov_after_fill, chain_rdy, chain_busy, aborted;
   logic [4:0]  pre_idx;
   logic        pre_ov;
   logic        ab_ir, ab_ov, ab_busy, ab_done;
   logic [31:0] ab_od;
   logic [4:0]  ab_oi;

   function automatic logic [31:0] ref_relu(input logic [31:0] v);
      return ($signed(v) < 0) ? 32'd0 : v;
   endfunction

   // Drives one frame from a start pulse and records what the DUT produced; judging is left to the caller.
   task automatic run_frame(input int bub, input bit rnd_rdy, input int stall_at, input int stall_len,
                            input bit pulse_starts, input bit chain, input int abort_at);
      int nin, nout, cyc, post, stall_left;
      bit v, r, rdy_pre, ovh, chain_pend;
      nin = 0; nout = 0; cyc = 0; post = 0; stall_left = stall_len; chain_pend = 0;
      n_done = 0; done_cyc = -1; ov_early = 0; st_n = 0; in_rdy_drain = 0;
      timeout = 0; ov_after_fill = 0; aborted = 0; chain_rdy = 0; chain_busy = 0;
      for (int k = 0; k < DEPTH; k++) begin
         got_dat[k] = 'x;
         got_idx[k] = 'x;
      end
      start = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
      @(posedge clk); #1; cyc = 1; start = 1'b0;
      while (1) begin
         if (chain_pend) begin
            chain_rdy = bus.in_ready; chain_busy = busy; chain_pend = 0;
         end
         if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (nout == DEPTH) begin
            post++;
            if (post > 4) break;
         end
         if (cyc > LIMIT) begin
            timeout = 1; break;
         end
         if (nin < DEPTH && bus.out_valid) ov_early++;
         if (nin == DEPTH && nout < DEPTH && bus.in_ready) in_rdy_drain++;
         if (abort_at >= 0 && nin == DEPTH && nout == abort_at) begin
            pre_idx = bus.out_idx; pre_ov = bus.out_valid;
            resetn = 1'b0;
            #1;
            ab_ir = bus.in_ready; ab_ov = bus.out_valid; ab_od = bus.out_data;
            ab_oi = bus.out_idx; ab_busy = busy; ab_done = done;
            aborted = 1;
            break;
         end
         if (nin < DEPTH) begin
            v = ($urandom_range(99) >= bub);
            bus.in_valid = v;
            bus.in_data  = v ? vals[nin] : $urandom;
         end else begin
            // Junk offered while draining must never reach the buffer.
            v = 0;
            bus.in_valid = (nout < DEPTH);
            bus.in_data  = $urandom;
         end
         rdy_pre = bus.in_ready;
         r = rnd_rdy ? ($urandom_range(1) == 1) : 1'b1;
         if (nin == DEPTH && nout == stall_at && stall_left > 0) begin
            r = 0;
            st_idx[st_n] = bus.out_idx; st_dat[st_n] = bus.out_data; st_ov[st_n] = bus.out_valid;
            st_n++; stall_left--;
         end
         bus.out_ready = r;
         ovh = bus.out_valid && r && (nout < DEPTH);
         if (ovh) begin
            got_idx[nout] = bus.out_idx; got_dat[nout] = bus.out_data;
         end
         start = pulse_starts && ((nin == 10) || (nin == DEPTH && nout == 5));
         if (chain && done) begin
            start = 1'b1; chain_pend = 1;
         end
         @(posedge clk); #1; cyc++;
         if (v && rdy_pre) begin
            nin++;
            if (nin == DEPTH) ov_after_fill = bus.out_valid;
         end
         if (ovh) nout++;
      end
      start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
      checks++; if (bus.out_idx !== 5'd0) begin errors++; $display("FAIL reset_out_idx: got %0d want 0", bus.out_idx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      resetn = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin
         errors++; $display("FAIL idle_after_reset: busy %b in_ready %b want 0 0", busy, bus.in_ready);
      end
   endtask

   task automatic test_ramp();
      for (int i = 0; i < DEPTH; i++) vals[i] = 32'(i - 16);
      run_frame(0, 0, -1, 0, 0, 0, -1);
      checks++; if (timeout) begin errors++; $display("FAIL ramp_timeout: frame did not complete within %0d cycles", LIMIT); end
      for (int k = 0; k < DEPTH; k++) begin
         checks++;
         if (got_idx[k] !== 5'(k) || got_dat[k] !== ref_relu(vals[k])) begin
            errors++;
            $display("FAIL ramp_out[%0d]: got idx %0d data %h, want idx %0d data %h", k, got_idx[k], got_dat[k], k, ref_relu(vals[k]));
         end
      end
      checks++; if (done_cyc != 65) begin errors++; $display("FAIL ramp_done_cycle: got %0d want 65", done_cyc); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL ramp_done_count: got %0d want 1", n_done); end
      checks++; if (ov_early != 0) begin errors++; $display("FAIL ramp_early_valid: got %0d want 0", ov_early); end
      checks++; if (ov_after_fill != 1'b1) begin errors++; $display("FAIL ramp_first_valid: got %b want 1", ov_after_fill); end
      checks++; if (in_rdy_drain != 0) begin errors++; $display("FAIL ramp_in_ready_drain: got %0d want 0", in_rdy_drain); end
   endtask

   task automatic test_boundary();
      logic [31:0] bin [5];
      logic [31:0] bexp [5];
      bin  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h7FFF_FFFF};
      bexp = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h7FFF_FFFF};
      for (int i = 0; i < DEPTH; i++) vals[i] = (i < 5) ? bin[i] : $urandom;
      run_frame(0, 0, -1, 0, 0, 0, -1);
      checks++; if (timeout) begin errors++; $display("FAIL bnd_timeout: frame did not complete"); end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (got_dat[k] !== bexp[k]) begin
            errors++; $display("FAIL bnd_value[%0d]: in %h got %h want %h", k, bin[k], got_dat[k], bexp[k]);
         end
      end
      for (int k = 5; k < DEPTH; k++) begin
         checks++;
         if (got_idx[k] !== 5'(k) || got_dat[k] !== ref_relu(vals[k])) begin
            errors++;
            $display("FAIL bnd_out[%0d]: got idx %0d data %h, want idx %0d data %h", k, got_idx[k], got_dat[k], k, ref_relu(vals[k]));
         end
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < DEPTH; i++) vals[i] = $urandom;
      run_frame(0, 0, 7, 5, 0, 0, -1);
      checks++; if (timeout) begin errors++; $display("FAIL bp_timeout: frame did not complete"); end
      checks++; if (st_n != 5) begin errors++; $display("FAIL bp_stall_cycles: got %0d want 5", st_n); end
      for (int s = 0; s < st_n; s++) begin
         checks++;
         if (st_idx[s] !== 5'd7 || st_dat[s] !== ref_relu(vals[7]) || st_ov[s] !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got idx %0d data %h valid %b, want idx 7 data %h valid 1", s, st_idx[s], st_dat[s], st_ov[s], ref_relu(vals[7]));
         end
      end
      for (int k = 0; k < DEPTH; k++) begin
         checks++;
         if (got_idx[k] !== 5'(k) || got_dat[k] !== ref_relu(vals[k])) begin
            errors++;
            $display("FAIL bp_out[%0d]: got idx %0d data %h, want idx %0d data %h", k, got_idx[k], got_dat[k], k, ref_relu(vals[k]));
         end
      end
      checks++; if (done_cyc != 70) begin errors++; $display("FAIL bp_done_cycle: got %0d want 70", done_cyc); end
   endtask

   task automatic test_bubbles();
      for (int i = 0; i < DEPTH; i++) vals[i] = $urandom;
      run_frame(40, 1, -1, 0, 0, 0, -1);
      checks++; if (timeout) begin errors++; $display("FAIL bub_timeout: frame did not complete"); end
      for (int k = 0; k < DEPTH; k++) begin
         checks++;
         if (got_idx[k] !== 5'(k) || got_dat[k] !== ref_relu(vals[k])) begin
            errors++;
            $display("FAIL bub_out[%0d]: got idx %0d data %h, want idx %0d data %h", k, got_idx[k], got_dat[k], k, ref_relu(vals[k]));
         end
      end
      checks++; if (ov_early != 0) begin errors++; $display("FAIL bub_early_valid: got %0d want 0", ov_early); end
      checks++; if (ov_after_fill != 1'b1) begin errors++; $display("FAIL bub_first_valid: got %b want 1", ov_after_fill); end
      checks++; if (in_rdy_drain != 0) begin errors++; $display("FAIL bub_in_ready_drain: got %0d want 0", in_rdy_drain); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL bub_done_count: got %0d want 1", n_done); end
   endtask

   task automatic test_start_ignored();
      for (int i = 0; i < DEPTH; i++) vals[i] = $urandom;
      run_frame(0, 0, -1, 0, 1, 1, -1);
      checks++; if (timeout) begin errors++; $display("FAIL st_timeout: frame did not complete"); end
      for (int k = 0; k < DEPTH; k++) begin
         checks++;
         if (got_idx[k] !== 5'(k) || got_dat[k] !== ref_relu(vals[k])) begin
            errors++;
            $display("FAIL st_out[%0d]: got idx %0d data %h, want idx %0d data %h", k, got_idx[k], got_dat[k], k, ref_relu(vals[k]));
         end
      end
      checks++; if (done_cyc != 65) begin errors++; $display("FAIL st_done_cycle: got %0d want 65", done_cyc); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL st_done_count: got %0d want 1", n_done); end
      checks++; if (chain_rdy != 1'b1 || chain_busy != 1'b1) begin
         errors++; $display("FAIL st_chain_fill: in_ready %b busy %b want 1 1", chain_rdy, chain_busy);
      end
   endtask

   // The DUT is already in FILL from the start coincident with done.
   task automatic test_back_to_back();
      for (int i = 0; i < DEPTH; i++) vals[i] = $urandom;
      run_frame(0, 0, -1, 0, 0, 0, -1);
      checks++; if (timeout) begin errors++; $display("FAIL b2b_timeout: frame did not complete"); end
      for (int k = 0; k < DEPTH; k++) begin
         checks++;
         if (got_idx[k] !== 5'(k) || got_dat[k] !== ref_relu(vals[k])) begin
            errors++;
            $display("FAIL b2b_out[%0d]: got idx %0d data %h, want idx %0d data %h", k, got_idx[k], got_dat[k], k, ref_relu(vals[k]));
         end
      end
      checks++; if (n_done != 1 || done_cyc != 65) begin
         errors++; $display("FAIL b2b_done: count %0d cycle %0d want 1 65", n_done, done_cyc);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < DEPTH; i++) vals[i] = $urandom;
      run_frame(0, 0, -1, 0, 0, 0, 20);
      checks++; if (aborted != 1'b1) begin errors++; $display("FAIL rst_reach_20: aborted %b timeout %b want 1 0", aborted, timeout); end
      checks++; if (pre_idx !== 5'd20 || pre_ov !== 1'b1) begin
         errors++; $display("FAIL rst_pre_state: idx %0d valid %b want 20 1", pre_idx, pre_ov);
      end
      checks++; if (ab_ir !== 1'b0 || ab_ov !== 1'b0 || ab_busy !== 1'b0 || ab_done !== 1'b0) begin
         errors++; $display("FAIL rst_async_ctrl: in_ready %b out_valid %b busy %b done %b want 0 0 0 0", ab_ir, ab_ov, ab_busy, ab_done);
      end
      checks++; if (ab_od !== 32'd0 || ab_oi !== 5'd0) begin
         errors++; $display("FAIL rst_async_data: data %h idx %0d want 0 0", ab_od, ab_oi);
      end
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_no_done[%0d]: done %b busy %b want 0 0", c, done, busy);
         end
      end
      for (int i = 0; i < DEPTH; i++) vals[i] = $urandom;
      run_frame(0, 0, -1, 0, 0, 0, -1);
      checks++; if (timeout) begin errors++; $display("FAIL rst_fresh_timeout: frame did not complete"); end
      for (int k = 0; k < DEPTH; k++) begin
         checks++;
         if (got_idx[k] !== 5'(k) || got_dat[k] !== ref_relu(vals[k])) begin
            errors++;
            $display("FAIL rst_fresh_out[%0d]: got idx %0d data %h, want idx %0d data %h", k, got_idx[k], got_dat[k], k, ref_relu(vals[k]));
         end
      end
      checks++; if (n_done != 1 || done_cyc != 65) begin
         errors++; $display("FAIL rst_fresh_done: count %0d cycle %0d want 1 65", n_done, done_cyc);
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_boundary();
      test_backpressure();
      test_bubbles();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fc1_relu_sequencer.md
Name: fc1_relu_sequencer

Overview:
- Buffers the 32 FC1 accumulator results as they arrive serially from the FC1 MAC engine, then streams them back out through signed ReLU to the FC2 stage, one per handshake.
- Owns the 5-bit sweep index that replaces the free-running selector counter in the FC1→FC2 path.
- Sits between the FC1 accumulator output and the FC2 operand input in the MNIST datapath.

Parameters:
- DATA_W, 32, width of each FC1 result (two's complement).
- DEPTH, 32, number of FC1 neurons buffered per frame.
- IDX_W, 5, index width; must equal clog2(DEPTH).

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- in_valid  input  1  FC1 result valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  DATA_W  FC1 result, signed, in neuron order 0..DEPTH-1.
- out_valid  output  1  ReLU result valid toward FC2.
- out_ready  input  1  FC2 accepts out_data this cycle.
- out_data  output  DATA_W  ReLU of the buffered result at out_idx.
- out_idx  output  IDX_W  neuron index of out_data.
- busy  output  1  high in FILL or DRAIN.
- done  output  1  one-cycle pulse after the final output handshake.

Behaviour:
- Reset is asynchronous, active-low: resetn low forces state IDLE, wr_ptr=0, rd_ptr=0, done=0. All outputs are 0 during and after reset (in_ready, out_valid, out_data, out_idx, busy, done). Buffer contents are not reset.
- State machine IDLE / FILL / DRAIN:
  - IDLE: in_ready=0, out_valid=0. If start=1, go to FILL next cycle with wr_ptr=0.
  - FILL: in_ready=1. Each in_valid&in_ready writes buf[wr_ptr]<=in_data and increments wr_ptr. The accept with wr_ptr==DEPTH-1 moves to DRAIN next cycle with wr_ptr wrapped to 0 and rd_ptr=0.
  - DRAIN: out_valid=1, out_idx=rd_ptr, out_data=relu(buf[rd_ptr]). Each out_valid&out_ready increments rd_ptr. The handshake with rd_ptr==DEPTH-1 returns to IDLE and pulses done for exactly one cycle, the first IDLE cycle.
- ReLU is signed: if in_data[DATA_W-1]==1 the output is 0, otherwise the value passes unchanged. 0 maps to 0, 32'h7FFFFFFF passes, 32'h80000000 maps to 0.
- out_data and out_idx are forced to 0 whenever out_valid=0.
- Latency: the first out_valid is asserted in the cycle after the 32nd input handshake. The minimum frame time is 1 (start) + 32 + 32 cycles.
- start is ignored in FILL and DRAIN, with no restart and no pointer change. A start in the same cycle as done is accepted, because the state is already IDLE.
- in_valid outside FILL is ignored: no write, and in_ready stays 0.
- out_ready held low in DRAIN stalls the output: out_data and out_idx hold stable and out_valid stays high.
- Pointers wrap modulo DEPTH. No overflow is possible, because FILL stops accepting at DEPTH.
- resetn asserted mid-FILL or mid-DRAIN aborts the frame immediately, with no done pulse. The next frame requires a new start.

Decomposition:
- Shared package mnist_pkg holds:
  - DATA_W, FC1_NEURONS (=32) and FC1_IDX_W (=5) constants.
  - A state enum type {IDLE, FILL, DRAIN}.
  - A relu function taking a signed DATA_W value.
- One natural sub-module, fc1_result_buf: a DEPTH×DATA_W register file with one synchronous write port and one combinational read port. The sequencer FSM, the pointers and the ReLU stay in fc1_relu_sequencer.

Test Plan:
- Reset, then start. Feed in_data = i-16 for i=0..31 with in_valid always high and out_ready always high. Required: outputs are 0 for idx 0..16 and 1..15 for idx 17..31. done pulses once, exactly 65 cycles after start.
- Boundary values: inputs 32'h80000000, 32'hFFFFFFFF, 0, 1, 32'h7FFFFFFF. Required outputs: 0, 0, 0, 1, 32'h7FFFFFFF.
- Backpressure: drive out_ready=0 for 5 cycles at idx 7. Required: out_idx stays 7, out_data is stable, out_valid stays high. No skipped or repeated indices.
- Input bubbles: toggle in_valid randomly during FILL. Required: all 32 values are stored in order, and DRAIN starts only after the 32nd accept.
- Start pulsed during FILL at wr_ptr=10 and during DRAIN: no effect. A start coincident with done begins a new FILL on the next cycle.
- resetn pulsed low at rd_ptr=20: all outputs go 0 asynchronously and no done pulse occurs. A fresh frame after reset completes correctly.
